severity_event_logger: RTL and testbench
========================================

// Module: severity_event_logger
// PURPOSE
//  Hardware sink for severity-tagged events (DEBUG=0, INFO=1, WARNING=2, ERROR=3): the synthesizable
//  counterpart of the simulation message tasks. On-chip sources post {severity, code} events. Events
//  are counted per severity and queued in a FIFO drained by a reader (UART/readout path). The first
//  ERROR latches a halt, as $finish does in simulation. One instance per clock domain.
// PARAMETERS
//  DEPTH            16  FIFO entries; power of 2, >=2
//  CODE_WIDTH       16  event code width
//  COUNT_WIDTH      16  per-severity counter width; counters saturate
//  TIMESTAMP_WIDTH  32  timestamp width (used only with SEVERITY_EVENT_LOGGER_TIMESTAMP_EN)
// PORTS
//  clock            in   1            single clock
//  reset_n          in   1            asynchronous, active-low reset
//  event_valid      in   1            source has an event
//  event_ready      out  1            logger accepts the event this cycle
//  event_severity   in   2            0..3 = DEBUG/INFO/WARNING/ERROR
//  event_code       in   CODE_WIDTH   event payload
//  min_severity     in   2            events below this are counted but not queued
//  clear_counts     in   1            1-cycle pulse: zero all counters
//  error_clear      in   1            1-cycle pulse: clear error_latched/halt
//  read_valid       out  1            FIFO head is valid
//  read_ready       in   1            reader takes the head
//  read_severity    out  2            head severity
//  read_code        out  CODE_WIDTH   head code
//  read_timestamp   out  TIMESTAMP_WIDTH  head timestamp (port exists only with macro)
//  count_debug/count_info/count_warning/count_error  out  COUNT_WIDTH  per-severity accept counts
//  error_latched    out  1            sticky: an ERROR was accepted
// BEHAVIOUR
//  - Reset (async assert, sync deassert on clock): FIFO empty, read_valid=0, read_* outputs=0,
//    all counts=0, error_latched=0, timestamp=0.
//  - Accept = event_valid & event_ready. event_ready = !full & !error_latched (combinational from
//    registered state; no dependence on event_valid or read_ready).
//  - Queue rule: an accepted event is written to the FIFO iff event_severity >= min_severity.
//    Filtered events are accepted and counted, never queued.
//  - Latency: queued event -> read_valid=1 on the next clock edge. Pop = read_valid & read_ready.
//    read_* are stable while read_valid=1 and read_ready=0.
//  - Full: event_ready=0 even if a pop occurs in the same cycle (no write-through at full).
//    Empty: read_valid=0; read_ready ignored. Simultaneous push and pop with count>0: occupancy
//    unchanged. Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  - Counters: +1 for the accepted severity; saturate at all-ones. clear_counts together with an
//    accept: counters zero, then the accepted severity's counter = 1.
//  - Error: accepting severity 3 sets error_latched on the next edge (that event is queued and
//    counted normally; it is never filtered). While latched, event_ready=0 and the FIFO keeps
//    draining. error_clear deasserts error_latched next edge; with simultaneous error_clear and an
//    ERROR accept, the latch stays set.
//  - Reset mid-operation discards queued events and counts immediately (async).
// CONFIGURATION
//  SEVERITY_EVENT_LOGGER_TIMESTAMP_EN defined: free-running TIMESTAMP_WIDTH counter (+1 per clock
//    from 0 at reset, wraps to 0) is captured at accept and stored per entry; read_timestamp exists.
//  Undefined: no counter, no timestamp storage, no read_timestamp port; all else identical.
// TESTING
//  1. reset_n=0 mid-stream with 5 queued -> read_valid=0, counts=0, error_latched=0 immediately.
//  2. min_severity=1; post DEBUG 0x0001, INFO 0x0002 -> count_debug=1, count_info=1; one read:
//     sev=1 code=0x0002 one cycle after accept.
//  3. DEPTH=16, read_ready=0, post 17 WARNINGs -> event_ready=0 after 16; count_warning=16;
//     pop+post same cycle at full -> no accept; next cycle accepts.
//  4. Post ERROR 0x00EE then INFO -> error_latched=1, INFO not accepted; drain gives sev=3
//     code=0x00EE; error_clear -> event_ready=1 again.
//  5. COUNT_WIDTH=4, 20 INFO accepts with continuous draining -> count_info=15; clear_counts with
//     an INFO accept -> count_info=1.
//  6. Macro on: accept at cycle 100 after reset -> read_timestamp=100; TIMESTAMP_WIDTH=8 wraps
//     255->0.

Source files
------------

// File: rtl/severity_event_logger.sv
// rtl/severity_event_logger.sv - severity-tagged event sink: per-severity counters, event FIFO, error halt latch
// Optional SEVERITY_EVENT_LOGGER_TIMESTAMP_EN: per-entry capture of a free-running timestamp.
module severity_event_logger #(
    parameter int DEPTH           = 16,
    parameter int CODE_WIDTH      = 16,
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMESTAMP_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       event_valid,
    output logic                       event_ready,
    input  logic [1:0]                 event_severity,
    input  logic [CODE_WIDTH-1:0]      event_code,
    input  logic [1:0]                 min_severity,
    input  logic                       clear_counts,
    input  logic                       error_clear,
    output logic                       read_valid,
    input  logic                       read_ready,
    output logic [1:0]                 read_severity,
    output logic [CODE_WIDTH-1:0]      read_code,
`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
    output logic [TIMESTAMP_WIDTH-1:0] read_timestamp,
`endif
    output logic [COUNT_WIDTH-1:0]     count_debug,
    output logic [COUNT_WIDTH-1:0]     count_info,
    output logic [COUNT_WIDTH-1:0]     count_warning,
    output logic [COUNT_WIDTH-1:0]     count_error,
    output logic                       error_latched
);

    localparam int AW = $clog2(DEPTH);
`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
    localparam int EW = 2 + CODE_WIDTH + TIMESTAMP_WIDTH;
`else
    localparam int EW = 2 + CODE_WIDTH;
`endif

    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [EW-1:0]          mem [DEPTH];
    logic [EW-1:0]          wdata;
    logic [EW-1:0]          head;
    logic [COUNT_WIDTH-1:0] cnt [4];
    logic                   full;
    logic                   empty;
    logic                   accept;
    logic                   push;
    logic                   pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign event_ready = !full && !error_latched;
    assign accept = event_valid && event_ready;
    assign push   = accept && (event_severity >= min_severity);
    assign pop    = !empty && read_ready;

`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
    logic [TIMESTAMP_WIDTH-1:0] timestamp;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            timestamp <= '0;
        else
            timestamp <= timestamp + 1'b1;
    end

    assign wdata          = {timestamp, event_severity, event_code};
    assign read_timestamp = empty ? '0 : head[EW-1 -: TIMESTAMP_WIDTH];
`else
    assign wdata = {event_severity, event_code};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; outputs are masked while empty so stale data never shows.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign read_valid    = !empty;
    assign read_severity = empty ? 2'b00 : head[CODE_WIDTH +: 2];
    assign read_code     = empty ? '0 : head[CODE_WIDTH-1:0];

    // A clear coinciding with an accept leaves that severity's counter at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (event_severity == 2'(i)))
                    cnt[i] <= clear_counts ? COUNT_WIDTH'(1) :
                              (&cnt[i] ? cnt[i] : cnt[i] + 1'b1);
                else if (clear_counts)
                    cnt[i] <= '0;
            end
        end
    end

    assign count_debug   = cnt[0];
    assign count_info    = cnt[1];
    assign count_warning = cnt[2];
    assign count_error   = cnt[3];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            error_latched <= 1'b0;
        else if (accept && (event_severity == 2'd3))
            error_latched <= 1'b1;
        else if (error_clear)
            error_latched <= 1'b0;
    end

endmodule

// File: tb/tb_severity_event_logger.sv
// tb/tb_severity_event_logger.sv - scoreboard bench for severity_event_logger
module tb_severity_event_logger;

    localparam int CW = 16;
    localparam int NW = 5;
    localparam int TW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          event_valid;
    logic          event_ready;
    logic [1:0]    event_severity;
    logic [CW-1:0] event_code;
    logic [1:0]    min_severity;
    logic          clear_counts;
    logic          error_clear;
    logic          read_valid;
    logic          read_ready;
    logic [1:0]    read_severity;
    logic [CW-1:0] read_code;
    logic [NW-1:0] count_debug, count_info, count_warning, count_error;
    logic          error_latched;
`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
    logic [TW-1:0] read_timestamp;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] sb [$];

    always #5 clock = ~clock;

    severity_event_logger #(
        .DEPTH(16), .CODE_WIDTH(CW), .COUNT_WIDTH(NW), .TIMESTAMP_WIDTH(TW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_severity(event_severity), .event_code(event_code),
        .min_severity(min_severity), .clear_counts(clear_counts), .error_clear(error_clear),
        .read_valid(read_valid), .read_ready(read_ready),
        .read_severity(read_severity), .read_code(read_code),
`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
        .read_timestamp(read_timestamp),
`endif
        .count_debug(count_debug), .count_info(count_info),
        .count_warning(count_warning), .count_error(count_error),
        .error_latched(error_latched)
    );

    // Every pop the DUT performs is checked against the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n && read_valid && read_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got sev=%0d code=%h, expected nothing", read_severity, read_code);
            end else begin
                logic [17:0] exp;
                exp = sb.pop_front();
                if ({read_severity, read_code} !== exp) begin
                    n_bad++;
                    $display("FAIL pop_data: got %h, expected %h", {read_severity, read_code}, exp);
                end
            end
        end
    end

    task automatic post(input logic [1:0] sev, input logic [CW-1:0] code, output bit accepted);
        event_valid = 1'b1; event_severity = sev; event_code = code;
        @(negedge clock);
        accepted = event_ready;
        if (accepted && sev >= min_severity)
            sb.push_back({sev, code});
        @(posedge clock); #1;
        event_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic drain();
        bit done = 0;
        read_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (!read_valid) done = 1;
        end
        @(posedge clock); #1;
        read_ready = 1'b0;
        n_cmp++;
        if (!done || sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: done=%0d left=%0d, expected empty", done, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp += 6;
        if (read_valid !== 1'b0) begin n_bad++; $display("FAIL rst_read_valid: got %b exp 0", read_valid); end
        if (event_ready !== 1'b1) begin n_bad++; $display("FAIL rst_event_ready: got %b exp 1", event_ready); end
        if (read_code !== '0 || read_severity !== 2'd0) begin n_bad++; $display("FAIL rst_read_data: got %h/%h exp 0", read_severity, read_code); end
        if ({count_debug, count_info, count_warning, count_error} !== '0) begin n_bad++; $display("FAIL rst_counts: got %h exp 0", {count_debug, count_info, count_warning, count_error}); end
        if (error_latched !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b exp 0", error_latched); end
        if (sb.size() != 0) begin n_bad++; $display("FAIL rst_sb: got %0d exp 0", sb.size()); end
    endtask

    task automatic test_filter();
        bit a;
        @(posedge clock); #1;
        min_severity = 2'd1;
        post(2'd0, 16'h0001, a);
        post(2'd1, 16'h0002, a);
        @(negedge clock);
        n_cmp += 5;
        if (count_debug !== 5'd1) begin n_bad++; $display("FAIL filt_count_debug: got %0d exp 1", count_debug); end
        if (count_info !== 5'd1) begin n_bad++; $display("FAIL filt_count_info: got %0d exp 1", count_info); end
        if (read_valid !== 1'b1) begin n_bad++; $display("FAIL filt_latency: got %b exp 1", read_valid); end
        if (read_severity !== 2'd1 || read_code !== 16'h0002) begin n_bad++; $display("FAIL filt_head: got %0d/%h exp 1/0002", read_severity, read_code); end
        if (sb.size() != 1) begin n_bad++; $display("FAIL filt_queued: got %0d exp 1", sb.size()); end
        @(posedge clock); #1;
        drain();
        min_severity = 2'd0;
    endtask

    task automatic test_full();
        bit a;
        int acc = 0;
        for (int i = 0; i < 17; i++) begin
            post(2'd2, CW'(16'h0200 + i), a);
            acc += a;
        end
        n_cmp += 2;
        if (acc != 16) begin n_bad++; $display("FAIL full_accepts: got %0d exp 16", acc); end
        if (count_warning !== 5'd16) begin n_bad++; $display("FAIL full_count_warning: got %0d exp 16", count_warning); end
        read_ready = 1'b1;
        post(2'd2, 16'h0300, a);
        read_ready = 1'b0;
        n_cmp++;
        if (a) begin n_bad++; $display("FAIL full_pop_post: got accept=1 exp 0"); end
        post(2'd2, 16'h0301, a);
        n_cmp++;
        if (!a) begin n_bad++; $display("FAIL full_next_accept: got accept=0 exp 1"); end
        drain();
    endtask

    task automatic test_error();
        bit a;
        logic [NW-1:0] info0;
        info0 = count_info;
        post(2'd3, 16'h00EE, a);
        post(2'd1, 16'h0011, a);
        n_cmp += 3;
        if (error_latched !== 1'b1) begin n_bad++; $display("FAIL err_latched: got %b exp 1", error_latched); end
        if (a) begin n_bad++; $display("FAIL err_blocks_info: got accept=1 exp 0"); end
        if (count_info !== info0) begin n_bad++; $display("FAIL err_info_count: got %0d exp %0d", count_info, info0); end
        drain();
        error_clear = 1'b1;
        @(posedge clock); #1;
        error_clear = 1'b0;
        n_cmp += 2;
        if (error_latched !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b exp 0", error_latched); end
        if (event_ready !== 1'b1) begin n_bad++; $display("FAIL err_ready: got %b exp 1", event_ready); end
        error_clear = 1'b1;
        post(2'd3, 16'h00EF, a);
        error_clear = 1'b0;
        n_cmp++;
        if (error_latched !== 1'b1) begin n_bad++; $display("FAIL err_clear_vs_set: got %b exp 1", error_latched); end
        drain();
        error_clear = 1'b1;
        @(posedge clock); #1;
        error_clear = 1'b0;
    endtask

    task automatic test_saturate();
        bit a;
        int acc = 0;
        clear_counts = 1'b1;
        @(posedge clock); #1;
        clear_counts = 1'b0;
        n_cmp++;
        if ({count_debug, count_info, count_warning, count_error} !== '0) begin n_bad++; $display("FAIL sat_clear: got %h exp 0", {count_debug, count_info, count_warning, count_error}); end
        read_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            post(2'd1, CW'(16'h0400 + i), a);
            acc += a;
        end
        n_cmp += 3;
        if (acc != 40) begin n_bad++; $display("FAIL sat_back_to_back: got %0d exp 40", acc); end
        if (count_info !== 5'd31) begin n_bad++; $display("FAIL sat_count_info: got %0d exp 31", count_info); end
        if (sb.size() > 1) begin n_bad++; $display("FAIL sat_occupancy: got %0d exp <=1", sb.size()); end
        clear_counts = 1'b1;
        post(2'd1, 16'h0500, a);
        clear_counts = 1'b0;
        n_cmp += 2;
        if (count_info !== 5'd1) begin n_bad++; $display("FAIL sat_clear_accept: got %0d exp 1", count_info); end
        if (count_debug !== 5'd0) begin n_bad++; $display("FAIL sat_clear_other: got %0d exp 0", count_debug); end
        drain();
    endtask

    task automatic test_reset_mid();
        bit a;
        for (int i = 0; i < 5; i++)
            post(2'd2, CW'(16'h0600 + i), a);
        post(2'd3, 16'h06EE, a);
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 3;
        if (read_valid !== 1'b0) begin n_bad++; $display("FAIL mid_read_valid: got %b exp 0", read_valid); end
        if ({count_debug, count_info, count_warning, count_error} !== '0) begin n_bad++; $display("FAIL mid_counts: got %h exp 0", {count_debug, count_info, count_warning, count_error}); end
        if (error_latched !== 1'b0) begin n_bad++; $display("FAIL mid_error: got %b exp 0", error_latched); end
        do_reset();
    endtask

`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
    task automatic test_timestamp();
        bit a;
        do_reset();
        repeat (100) @(posedge clock);
        #1;
        post(2'd1, 16'h0700, a);
        @(negedge clock);
        n_cmp++;
        if (read_timestamp !== 8'd100) begin n_bad++; $display("FAIL ts_100: got %0d exp 100", read_timestamp); end
        drain();
        do_reset();
        repeat (255) @(posedge clock);
        #1;
        post(2'd1, 16'h0701, a);
        post(2'd1, 16'h0702, a);
        @(negedge clock);
        n_cmp++;
        if (read_timestamp !== 8'd255) begin n_bad++; $display("FAIL ts_255: got %0d exp 255", read_timestamp); end
        read_ready = 1'b1;
        @(posedge clock); #1;
        read_ready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (read_timestamp !== 8'd0) begin n_bad++; $display("FAIL ts_wrap: got %0d exp 0", read_timestamp); end
        drain();
    endtask
`endif

    initial begin
        event_valid = 0; event_severity = 0; event_code = '0; min_severity = 0;
        clear_counts = 0; error_clear = 0; read_ready = 0;
        do_reset();
        test_reset();
        test_filter();
        test_full();
        test_error();
        test_saturate();
        test_reset_mid();
        test_reset();
`ifdef SEVERITY_EVENT_LOGGER_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
